// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch sequencer.
// Issues fetch requests to instruction memory, delivers fetched words with their
// PC, and redirects the fetch stream on branch, jump and register-jump requests.
// A redirect that arrives while a fetch is outstanding is remembered as a pending
// target. The word returned for that fetch is discarded and fetching resumes at
// the pending target.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] branch_addr,
    input  logic [27:0] jump_addr,
    input  logic [31:0] jr_addr,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        stall,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HALTED
    } state_t;

    state_t      state;
    logic [31:0] fetch_addr;
    logic        pending;
    logic [31:0] pend_target;

    logic [31:0] base;
    logic        redirect;
    logic [31:0] target;

    // The address is held in a register, so it stays stable for the whole request.
    assign imem_addr = fetch_addr;

    // Redirect target relative to the instruction after the last delivered one.
    // Later assignments override earlier ones: jump_reg > jump > branch_taken.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        base     = pc + 32'd4;
        redirect = jump_reg | jump | branch_taken;
        target   = base + (branch_addr << 2);
        if (jump)
            target = {base[31:28], jump_addr};
        if (jump_reg)
            target = jr_addr;
    end

    // Fetch FSM, with the state and all outputs registered in one block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking (<=) assignments, so all flops update together.
            state       <= S_IDLE;
            fetch_addr  <= RESET_VECTOR;
            pending     <= 1'b0;
            pend_target <= '0;
            imem_req    <= 1'b0;
            inst_valid  <= 1'b0;
            inst        <= '0;
            pc          <= RESET_VECTOR;
            halted      <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (halt) begin
                        state    <= S_HALTED;
                        halted   <= 1'b1;
                        imem_req <= 1'b0;
                    end else begin
                        if (redirect)
                            fetch_addr <= target;
                        if (!stall) begin
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                        end
                    end
                end

                S_REQ: begin
                    if (!imem_ack) begin
                        // Remember the newest redirect until the outstanding fetch returns.
                        if (redirect) begin
                            pending     <= 1'b1;
                            pend_target <= target;
                        end
                    end else begin
                        if (redirect || pending) begin
                            // The returned word is on the wrong path: drop it and steer.
                            fetch_addr <= redirect ? target : pend_target;
                            pending    <= 1'b0;
                        end else begin
                            inst_valid <= 1'b1;
                            inst       <= imem_rdata;
                            pc         <= fetch_addr;
                            fetch_addr <= fetch_addr + 32'd4;
                        end
                        if (halt) begin
                            state    <= S_HALTED;
                            halted   <= 1'b1;
                            imem_req <= 1'b0;
                        end else if (stall) begin
                            state    <= S_IDLE;
                            imem_req <= 1'b0;
                        end else begin
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                        end
                    end
                end

                S_HALTED: begin
                    state    <= S_HALTED;
                    imem_req <= 1'b0;
                    halted   <= 1'b1;
                end

                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: a directed sequence with a scoreboard of the
// instructions expected to be delivered.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] branch_addr;
    logic [27:0] jump_addr;
    logic [31:0] jr_addr;
    logic        branch_taken, jump, jump_reg;
    logic        stall, halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        halted;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } deliv_t;

    deliv_t exp_q[$];

    pc_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .branch_addr(branch_addr), .jump_addr(jump_addr), .jr_addr(jr_addr),
        .branch_taken(branch_taken), .jump(jump), .jump_reg(jump_reg),
        .stall(stall), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory contents as a function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h5A5A_0000;
    endfunction

    // Wait (bounded) at falling edges for a request, then check its address.
    task automatic wait_req(input logic [31:0] exp_addr);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", imem_req, 1'b1);
        check("req_addr", imem_addr, exp_addr);
    endtask

    // Hold the request for lat cycles with no ack, checking the address stays put.
    task automatic hold_req(input logic [31:0] exp_addr, input int lat);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check("req_hold", imem_req, 1'b1);
            check("addr_stable", imem_addr, exp_addr);
        end
    endtask

    // Return the word for one cycle and push it to the scoreboard if it should be delivered.
    task automatic do_ack(input logic [31:0] a, input bit deliver);
        deliv_t d;
        imem_ack   = 1'b1;
        imem_rdata = mem_word(a);
        if (deliver) begin
            d.addr = a;
            d.data = mem_word(a);
            exp_q.push_back(d);
        end
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic fetch(input logic [31:0] a, input int lat, input bit deliver);
        wait_req(a);
        hold_req(a, lat);
        do_ack(a, deliver);
    endtask

    // Delivered-instruction monitor: every pulse must match the head of the scoreboard.
    always @(posedge clk) begin
        #1;
        if (inst_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("valid_without_expect", inst_valid, 1'b0);
            end else begin
                deliv_t d;
                d = exp_q.pop_front();
                check("deliv_pc", pc, d.addr);
                check("deliv_inst", inst, d.data);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        branch_addr = '0; jump_addr = '0; jr_addr = '0;
        branch_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0;
        stall = 1'b0; halt = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", inst_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        rst_n = 1'b1;

        // Sequential fetch, ack one cycle after each request
        fetch(32'h0, 1, 1'b1);
        fetch(32'h4, 1, 1'b1);
        fetch(32'h8, 1, 1'b1);

        // jump_reg during an outstanding fetch: word dropped, resume at 0x100
        wait_req(32'hC);
        jump_reg = 1'b1; jr_addr = 32'h100;
        @(negedge clk);
        jump_reg = 1'b0;
        do_ack(32'hC, 1'b0);

        // stall during REQ: fetch completes, one delivery, then idle
        stall = 1'b1;
        fetch(32'h100, 1, 1'b1);
        check("stall_idle_req", imem_req, 1'b0);
        repeat (2) @(negedge clk);
        check("stall_idle_req2", imem_req, 1'b0);

        // Branch in IDLE: 0x104 + (-2 << 2) = 0xFC
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFE;
        @(negedge clk);
        branch_taken = 1'b0;
        check("branch_idle_addr", imem_addr, 32'h0FC);
        check("branch_idle_req", imem_req, 1'b0);
        stall = 1'b0;
        fetch(32'h0FC, 0, 1'b1);

        // Get to pc = 0x3000_0010
        wait_req(32'h100);
        jump_reg = 1'b1; jr_addr = 32'h3000_0010;
        @(negedge clk);
        jump_reg = 1'b0;
        do_ack(32'h100, 1'b0);
        fetch(32'h3000_0010, 0, 1'b1);

        // Jump during the outstanding fetch, ack three cycles later
        wait_req(32'h3000_0014);
        jump = 1'b1; jump_addr = 28'h000_0040;
        @(negedge clk);
        jump = 1'b0;
        hold_req(32'h3000_0014, 2);
        do_ack(32'h3000_0014, 1'b0);

        // jump_reg and branch_taken in the same cycle: jump_reg wins
        wait_req(32'h3000_0040);
        jump_reg = 1'b1; jr_addr = 32'h200;
        branch_taken = 1'b1; branch_addr = 32'h10;
        @(negedge clk);
        jump_reg = 1'b0; branch_taken = 1'b0;
        do_ack(32'h3000_0040, 1'b0);

        // Branch in the ack cycle itself: 0x3000_0014 + (1 << 2)
        wait_req(32'h200);
        branch_taken = 1'b1; branch_addr = 32'h1;
        do_ack(32'h200, 1'b0);
        branch_taken = 1'b0;

        // A second redirect before the ack overwrites the stored target
        wait_req(32'h3000_0018);
        jump_reg = 1'b1; jr_addr = 32'h500;
        @(negedge clk);
        jr_addr = 32'h600;
        @(negedge clk);
        jump_reg = 1'b0;
        do_ack(32'h3000_0018, 1'b0);

        // halt during REQ: deliver, then halted for good
        halt = 1'b1;
        fetch(32'h600, 0, 1'b1);
        halt = 1'b0;
        jump_reg = 1'b1; jr_addr = 32'h1234;
        repeat (3) begin
            @(negedge clk);
            check("halted_flag", halted, 1'b1);
            check("halted_req", imem_req, 1'b0);
            check("halted_addr", imem_addr, 32'h604);
        end
        jump_reg = 1'b0;

        // Reset pulse leaves HALTED, fetch restarts at the reset vector
        rst_n = 1'b0;
        #1;
        check("rst2_halted", halted, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_req(32'h0);

        // Reset in the middle of an outstanding fetch: nothing delivered
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req", imem_req, 1'b0);
        check("midrst_valid", inst_valid, 1'b0);
        check("midrst_pc", pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        fetch(32'h0, 1, 1'b1);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the first instruction fetch address after reset.
REQ-002 Ports SHALL be as follows:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- branch_addr  in  32  sign-extended word offset from the address extender.
- jump_addr  in  28  byte jump field ({field26,2'b00}) from the address extender.
- jr_addr  in  32  register jump target.
- branch_taken, jump, jump_reg  in  1 each  redirect request pulses.
- stall  in  1  inhibits issue of new fetches.
- halt  in  1  stop fetching.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  fetch complete.
- imem_rdata  in  32  fetched word, valid with imem_ack.
- inst_valid  out  1  one-cycle pulse: inst/pc hold a delivered instruction.
- inst  out  32  delivered instruction.
- pc  out  32  address of the last delivered instruction.
- halted  out  1  high in HALTED.

Function
REQ-003 Internal state SHALL be: fetch_addr (32b), pending flag and pending target (32b), and FSM states IDLE, REQ, HALTED.
REQ-004 imem_req SHALL be 1 only in REQ; imem_addr SHALL equal fetch_addr and SHALL stay stable while imem_req=1 and imem_ack=0.
REQ-005 IDLE: if halt=1, next state SHALL be HALTED; else if stall=0, next state SHALL be REQ; else remain IDLE.
REQ-006 REQ: if imem_ack=0, remain REQ.
REQ-007 REQ with imem_ack=1, no pending, no redirect that cycle: next cycle inst_valid=1, inst=imem_rdata, pc=fetch_addr, fetch_addr=fetch_addr+4 (mod 2^32).
REQ-008 After an ack, next state SHALL be HALTED if halt=1, IDLE if stall=1, else REQ (back-to-back fetch, imem_req remains 1 with new address).
REQ-009 Redirect target SHALL be computed from base = pc+4:
- jump_reg: jr_addr.
- jump: {base[31:28], jump_addr}.
- branch_taken: base + (branch_addr<<2), truncated to 32 bits.
REQ-010 Simultaneous redirect inputs SHALL resolve with priority jump_reg > jump > branch_taken.
REQ-011 Redirect in IDLE SHALL load fetch_addr with the target on the next edge.
REQ-012 Redirect in REQ, including the ack cycle, SHALL set pending and store the target; a later redirect before the ack SHALL overwrite the stored target.
REQ-013 On ack with pending set (or with a redirect in the ack cycle), the fetched word SHALL be discarded:
- inst_valid stays 0 and pc/inst are unchanged.
- fetch_addr is loaded with the target and pending is cleared.
REQ-014 stall SHALL NOT cancel an outstanding request; the request completes per REQ-007/013.
REQ-015 halt SHALL take effect only at IDLE or at ack. HALTED SHALL hold imem_req=0 and halted=1, ignore all inputs, and be left only via reset.
REQ-016 inst_valid SHALL never be high for two cycles from one ack.

Reset
REQ-017 rst_n=0 SHALL asynchronously force:
- state=IDLE, imem_req=0, inst_valid=0, halted=0, pending=0.
- fetch_addr=RESET_VECTOR, pc=RESET_VECTOR, inst=0.
REQ-018 Reset asserted mid-fetch SHALL abandon the request without delivering an instruction. After release, the first imem_addr SHALL be RESET_VECTOR.

Verification
REQ-019 Reset release, stall=0, ack one cycle after each request -> imem_addr sequence 0x0,0x4,0x8; inst_valid pulses with pc=0x0,0x4,0x8 and inst equal to imem_rdata.
REQ-020 Deliver pc=0x100, then pulse branch_taken with branch_addr=32'hFFFF_FFFE while in IDLE -> next imem_addr=0x0FC.
REQ-021 Deliver pc=0x3000_0010; pulse jump with jump_addr=28'h0000_040 during an outstanding fetch, ack 3 cycles later -> no inst_valid for that fetch; next imem_addr=0x3000_0040.
REQ-022 jump_reg (jr_addr=0x200) and branch_taken in the same cycle -> next imem_addr=0x200.
REQ-023 stall=1 during REQ, ack arrives -> one inst_valid pulse, FSM in IDLE, imem_req=0 until stall=0.
REQ-024 halt=1 during REQ -> instruction delivered on ack, then halted=1, imem_req=0 permanently; rst_n pulse -> imem_addr=RESET_VECTOR.
